rojobot_wb_poller: RTL

ROJOBOT_WB_POLLER -- requirements
Module: rojobot_wb_poller

---
 rtl/rojobot_wb_poller_pkg.sv | 30 +++
 rtl/rojobot_wb_poller_wb_master_cycle.sv | 63 ++++++
 rtl/rojobot_wb_poller.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rojobot_wb_poller_pkg.sv
// Shared types and register map for the Rojobot Wishbone poller.
// Offsets are relative to the bot register window base address.
package rojobot_wb_poller_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_POLL,
        S_INFO,
        S_ACK1,
        S_ACK0,
        S_CTRL
    } state_t;

    localparam logic [31:0] OFS_INFO   = 32'h0000_000C;
    localparam logic [31:0] OFS_CTRL   = 32'h0000_0010;
    localparam logic [31:0] OFS_UPDT   = 32'h0000_0014;
    localparam logic [31:0] OFS_INTACK = 32'h0000_0018;

    // Saturating load value for the 16-bit poll interval counter.
    function automatic logic [15:0] wait_load(input int div);
        if (div <= 1)
            return 16'h0000;
        else if (div > 65536)
            return 16'hFFFF;
        else
            return 16'(div - 1);
    endfunction

endpackage

// File: rtl/rojobot_wb_poller_wb_master_cycle.sv
// Single-transfer Wishbone initiator: one classic cycle per start,
// ended by ack, err, rtry or a cycle-length timeout.
module wb_master_cycle #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] adr,
    input  logic [31:0] wdat,
    input  logic        we,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rtry_i,
    output logic        done,
    output logic        fail
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic          cyc;
    logic [CW-1:0] cnt;
    logic          reply;
    logic          expired;

    assign reply   = wb_ack_i || wb_err_i || wb_rtry_i;
    assign expired = cyc && !reply && (cnt == LAST);
    // err/rtry win over a simultaneous ack
    assign done    = cyc && wb_ack_i && !wb_err_i && !wb_rtry_i;
    assign fail    = cyc && (wb_err_i || wb_rtry_i || expired);

    assign wb_cyc_o = cyc;
    assign wb_stb_o = cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc      <= 1'b0;
            cnt      <= '0;
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            wb_we_o  <= 1'b0;
        end else if (done || fail) begin
            cyc      <= 1'b0;
            wb_dat_o <= 32'h0;
            wb_we_o  <= 1'b0;
        end else if (cyc) begin
            cnt <= cnt + CW'(1);
        end else if (start) begin
            cyc      <= 1'b1;
            cnt      <= '0;
            wb_adr_o <= adr;
            wb_dat_o <= wdat;
            wb_we_o  <= we;
        end
    end

endmodule

// File: rtl/rojobot_wb_poller.sv
// Polls the Rojobot update flag over Wishbone, fetches BotInfo,
// acknowledges the update and writes the motor command.
module rojobot_wb_poller
    import rojobot_wb_poller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          POLL_DIV  = 1000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  motctl,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rtry_i,
    output logic [31:0] bot_info,
    output logic        info_valid,
    output logic        bus_err,
    output logic        busy
);

    localparam logic [15:0] WAIT_LOAD = wait_load(POLL_DIV);

    state_t      state;
    state_t      state_nx;
    logic [15:0] wait_cnt;
    logic [15:0] wait_nx;
    logic        start;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic        done;
    logic        fail;

    assign wb_sel_o = 4'hF;
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;
    assign busy     = (state != S_IDLE) && (state != S_WAIT);

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        adr      = BASE_ADDR + OFS_UPDT;
        wdat     = 32'h0;
        we       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!enable)
                    state_nx = S_IDLE;
                else if (wait_cnt == 16'h0)
                    state_nx = S_POLL;
                else
                    wait_nx = wait_cnt - 16'h1;
            end
            S_POLL: begin
                adr = BASE_ADDR + OFS_UPDT;
                if (done)
                    state_nx = wb_dat_i[0] ? S_INFO : S_WAIT;
            end
            S_INFO: begin
                adr = BASE_ADDR + OFS_INFO;
                if (done)
                    state_nx = S_ACK1;
            end
            S_ACK1: begin
                adr  = BASE_ADDR + OFS_INTACK;
                wdat = 32'h1;
                we   = 1'b1;
                if (done)
                    state_nx = S_ACK0;
            end
            S_ACK0: begin
                adr = BASE_ADDR + OFS_INTACK;
                we  = 1'b1;
                if (done)
                    state_nx = S_CTRL;
            end
            S_CTRL: begin
                adr  = BASE_ADDR + OFS_CTRL;
                wdat = {24'h0, motctl};
                we   = 1'b1;
                if (done)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // a failed transfer abandons the whole pass
        if (fail)
            state_nx = S_WAIT;
        if (state_nx == S_WAIT && state != S_WAIT)
            wait_nx = WAIT_LOAD;
    end

    // launch in the first cycle of each bus state; engine is idle there
    assign start = busy && !wb_cyc_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 16'h0;
            bot_info   <= 32'h0;
            info_valid <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_nx;
            info_valid <= (state == S_INFO) && done;
            if ((state == S_INFO) && done)
                bot_info <= wb_dat_i;
            if (fail)
                bus_err <= 1'b1;
        end
    end

    wb_master_cycle #(
        .TIMEOUT(TIMEOUT)
    ) u_cycle (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .adr      (adr),
        .wdat     (wdat),
        .we       (we),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rtry_i(wb_rtry_i),
        .done     (done),
        .fail     (fail)
    );

endmodule
